// File: rtl/i2s_rx_if.sv
// I2S receiver bundle: serial pins in, committed stereo words and status out.
interface i2s_rx_if #(
  parameter int DATA_WIDTH = 16
);
  logic                  i2s_bck;
  logic                  i2s_lrck;
  logic                  i2s_data;
  logic [DATA_WIDTH-1:0] left_data;
  logic [DATA_WIDTH-1:0] right_data;
  logic                  sample_valid;
  logic                  locked;
  logic                  short_word;

  modport slave (
    input  i2s_bck,
    input  i2s_lrck,
    input  i2s_data,
    output left_data,
    output right_data,
    output sample_valid,
    output locked,
    output short_word
  );

  modport master (
    output i2s_bck,
    output i2s_lrck,
    output i2s_data,
    input  left_data,
    input  right_data,
    input  sample_valid,
    input  locked,
    input  short_word
  );
endinterface

// File: rtl/i2s_rx.sv
// I2S slave receiver: synchronizes BCK/LRCK/DATA into clk, assembles
// left/right words and presents them as a registered stereo pair.
module i2s_rx #(
  parameter int DATA_WIDTH = 16
) (
  input  logic    clk,
  input  logic    rst,
  i2s_rx_if.slave bus
);
  localparam int CW = $clog2(DATA_WIDTH + 1);

  typedef enum logic [1:0] {
    HUNT  = 2'd0,
    LEFT  = 2'd1,
    RIGHT = 2'd2
  } state_t;

  state_t state, state_n;

  logic bck_s1, bck_s2, bck_s3;
  logic lr_s1, lr_s2;
  logic d_s1, d_s2;
  logic ev_q, lr_q, d_q;

  logic                  lrp, lrp_n;
  logic [CW-1:0]         cnt, cnt_n, cap_cnt;
  logic [DATA_WIDTH-1:0] sh, sh_n, cap_sh;
  logic [DATA_WIDTH-1:0] word, pend, pend_n;
  logic [DATA_WIDTH-1:0] left_q, left_n;
  logic [DATA_WIDTH-1:0] right_q, right_n;
  logic                  sv_q, sv_n;
  logic                  sw_q, sw_n;
  logic                  lock_q, lock_n;
  logic                  bnd, short;

  // Edge detect is registered together with its LRCK/DATA samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      bck_s1 <= 1'b0;
      bck_s2 <= 1'b0;
      bck_s3 <= 1'b0;
      lr_s1  <= 1'b0;
      lr_s2  <= 1'b0;
      d_s1   <= 1'b0;
      d_s2   <= 1'b0;
      ev_q   <= 1'b0;
      lr_q   <= 1'b0;
      d_q    <= 1'b0;
    end else begin
      bck_s1 <= bus.i2s_bck;
      bck_s2 <= bck_s1;
      bck_s3 <= bck_s2;
      lr_s1  <= bus.i2s_lrck;
      lr_s2  <= lr_s1;
      d_s1   <= bus.i2s_data;
      d_s2   <= d_s1;
      ev_q   <= bck_s2 & ~bck_s3;
      lr_q   <= lr_s2;
      d_q    <= d_s2;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= HUNT;
      lrp     <= 1'b0;
      cnt     <= '0;
      sh      <= '0;
      pend    <= '0;
      left_q  <= '0;
      right_q <= '0;
      sv_q    <= 1'b0;
      sw_q    <= 1'b0;
      lock_q  <= 1'b0;
    end else begin
      state   <= state_n;
      lrp     <= lrp_n;
      cnt     <= cnt_n;
      sh      <= sh_n;
      pend    <= pend_n;
      left_q  <= left_n;
      right_q <= right_n;
      sv_q    <= sv_n;
      sw_q    <= sw_n;
      lock_q  <= lock_n;
    end
  end

  always_comb begin
    state_n = state;
    lrp_n   = lrp;
    cnt_n   = cnt;
    sh_n    = sh;
    pend_n  = pend;
    left_n  = left_q;
    right_n = right_q;
    sv_n    = 1'b0;
    sw_n    = 1'b0;
    lock_n  = lock_q;
    cap_sh  = sh;
    cap_cnt = cnt;
    if (cnt < CW'(DATA_WIDTH)) begin
      cap_sh  = {sh[DATA_WIDTH-2:0], d_q};
      cap_cnt = cnt + CW'(1);
    end
    // Left-justify short words; long words already hold their MSBs.
    word  = cap_sh << (DATA_WIDTH - int'(cap_cnt));
    short = cap_cnt < CW'(DATA_WIDTH);
    bnd   = lr_q != lrp;
    if (ev_q) begin
      lrp_n = lr_q;
      sh_n  = cap_sh;
      cnt_n = cap_cnt;
      if (bnd) begin
        sh_n  = '0;
        cnt_n = '0;
        unique case (1'b1)
          (state == HUNT): begin
            if (!lr_q) state_n = LEFT;
          end
          (state == LEFT): begin
            pend_n  = word;
            sw_n    = short;
            state_n = RIGHT;
          end
          (state == RIGHT): begin
            left_n  = pend;
            right_n = word;
            sv_n    = 1'b1;
            sw_n    = short;
            lock_n  = 1'b1;
            state_n = LEFT;
          end
          default: state_n = HUNT;
        endcase
      end
    end
  end

  assign bus.left_data    = left_q;
  assign bus.right_data   = right_q;
  assign bus.sample_valid = sv_q;
  assign bus.short_word   = sw_q;
  assign bus.locked       = lock_q;
endmodule

// File: doc/i2s_rx.md
I2S_RX -- requirements
Module: i2s_rx

Interface
REQ-001 Parameter DATA_WIDTH, default 16: captured bits per channel word, range 8..32.
REQ-002 Port clk  input  1  system clock (25 MHz); all logic on rising edge; single clock domain.
REQ-003 Port rst  input  1  reset; synchronous, active-high.
REQ-004 Port i2s_bck  input  1  I2S bit clock; asynchronous to clk; frequency at most clk/4.
REQ-005 Port i2s_lrck  input  1  I2S word select; low = left channel, high = right channel.
REQ-006 Port i2s_data  input  1  I2S serial data, MSB first.
REQ-007 Port left_data  output  DATA_WIDTH  last committed left word, two's complement.
REQ-008 Port right_data  output  DATA_WIDTH  last committed right word, two's complement.
REQ-009 Port sample_valid  output  1  one-clk pulse; left_data/right_data hold a new stereo pair.
REQ-010 Port locked  output  1  high once the first complete left+right frame has been captured.
REQ-011 Port short_word  output  1  one-clk pulse; a committed word had fewer than DATA_WIDTH bits.

Function
REQ-012 i2s_bck, i2s_lrck and i2s_data shall each pass through a 2-flop synchronizer; a third flop on BCK shall feed a rising-edge detector.
REQ-013 All capture actions shall occur only in the clk cycle of a detected BCK rise ("bit event"); LRCK and DATA shall be taken from the same synchronizer stage as the BCK used for the detection.
REQ-014 At each bit event, if bit_count < DATA_WIDTH, shift the DATA bit into the shift register LSB-side and increment bit_count; otherwise drop the bit.
REQ-015 At each bit event, compare sampled LRCK with the stored LRCK of the previous bit event; a difference is a word boundary.
REQ-016 At a word boundary, the bit of that same event is the final bit of the ending word (standard I2S one-BCK delay) and shall be handled per REQ-014 before the commit.
REQ-017 Commit: word = shift register shifted left by (DATA_WIDTH - bit_count), zero-filling LSBs; store in left or right holding register per the ending word's LRCK level.
REQ-018 On commit, bit_count and the shift register shall clear to 0; the next bit event is the MSB of the new word.
REQ-019 short_word shall pulse on any commit with bit_count < DATA_WIDTH, except the first (partial) word after reset.
REQ-020 State machine: HUNT (discard words until an LRCK high-to-low boundary) -> LEFT (capture left) -> RIGHT (capture right) -> LEFT ...; HUNT is left only at a high-to-low boundary.
REQ-021 At a low-to-high boundary in LEFT, commit the left word to an internal pending register and enter RIGHT.
REQ-022 At a high-to-low boundary in RIGHT, commit the right word, copy pending left and new right to left_data/right_data in the same cycle, pulse sample_valid, set locked, enter LEFT.
REQ-023 Outputs shall be registered; sample_valid shall assert exactly 3 clk cycles after the clk edge at which the BCK pin high level is first registered by the first synchronizer flop.
REQ-024 left_data/right_data shall change only in the sample_valid cycle and hold otherwise.
REQ-025 Words with more than DATA_WIDTH bits shall keep their DATA_WIDTH MSBs and set no flag.
REQ-026 A boundary without an intervening bit event cannot occur; LRCK changes between bit events shall be ignored until the next bit event.
REQ-027 Once locked, locked shall stay high until reset.

Reset
REQ-028 On rst: state = HUNT; left_data = 0, right_data = 0, sample_valid = 0, locked = 0, short_word = 0; bit_count, shift and pending registers = 0; stored LRCK = 0; synchronizer flops = 0.
REQ-029 Reset asserted mid-word shall discard the partial word; no sample_valid or short_word shall follow from pre-reset bits.

Verification
REQ-030 BCK = clk/8, 16-bit I2S, frames L=16'h1234, R=16'hABCD repeated -> first sample_valid after one full frame past the first high-to-low LRCK; left_data=16'h1234, right_data=16'hABCD; locked=1.
REQ-031 32 BCKs per channel, L=32'h80017FFF..., DATA_WIDTH=16 -> left_data=16'h8001, short_word never pulses.
REQ-032 12 BCKs per channel, L=12'hFFF, R=12'h800 -> left_data=16'hFFF0, right_data=16'h8000, short_word pulses twice per frame.
REQ-033 Start stream mid right-channel -> that partial word and the following left word before a high-to-low boundary produce no sample_valid; first output pair is fully captured.
REQ-034 Assert rst for 2 clk in the middle of a left word -> all outputs 0 and locked=0 next cycle; relock after next complete frame with correct data.
REQ-035 Check sample_valid latency: BCK pin rise carrying the last right bit -> sample_valid exactly 3 clk later, width 1 clk.
